// File: rtl/serial_pkg.sv
// serial_pkg: shared helpers for the bit-serial adder.
// Provides the counter-width rule and the full-adder bit functions.
// Optional feature macro used by the slice: SERIAL_ADDER_OVF_EN.
package serial_pkg;
  localparam int MAX_WIDTH = 65535;
  // A modulo-WIDTH counter needs $clog2(WIDTH) bits, but never fewer than one.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: bit-serial adder bus.
// Signals:
//   in1, in2   operand bits, LSB first (driven by master)
//   sum        registered sum bit
//   carry_out  registered carry of the bit on sum
//   word_end   sum holds the MSB of a framed word
//   ovf        signed overflow on word_end (only with SERIAL_ADDER_OVF_EN)
interface serial_adder_if;
  logic in1;
  logic in2;
  logic sum;
  logic carry_out;
  logic word_end;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
  modport master(output in1, in2, input sum, carry_out, word_end, ovf);
  modport slave(input in1, in2, output sum, carry_out, word_end, ovf);
`else
  modport master(output in1, in2, input sum, carry_out, word_end);
  modport slave(input in1, in2, output sum, carry_out, word_end);
`endif
endinterface

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: modulo-WIDTH bit counter with terminal-count flag.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   tc   high while the counter sits on WIDTH-1 (the word's MSB)
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tc
);
  localparam int CW = cnt_w(WIDTH);
  logic [CW-1:0] cnt;
  assign tc = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial two-operand adder, LSB first, one sum bit per clock.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   bus  serial_adder_if.slave (in1, in2, sum, carry_out, word_end [, ovf])
// Parameter WIDTH: 0 = free-running carry; 1..65535 = framed words whose
// carry clears after the MSB. Macro SERIAL_ADDER_OVF_EN adds the ovf output.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 0
) (
  input  logic            clk,
  input  logic            rst,
  serial_adder_if.slave   bus
);
  logic c;
  logic maj;
  logic last;
  assign maj = fa_carry(bus.in1, bus.in2, c);
  generate
    if (WIDTH > 0) begin : g_frame
      serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (.clk(clk), .rst(rst), .tc(last));
    end else begin : g_free
      assign last = 1'b0;
    end
  endgenerate
  // The stored carry drops to 0 after the MSB so the next word starts clean,
  // while carry_out still reports the true MSB carry.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      c             <= 1'b0;
      bus.sum       <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.word_end  <= 1'b0;
    end else begin
      c             <= maj & ~last;
      bus.sum       <= fa_sum(bus.in1, bus.in2, c);
      bus.carry_out <= maj;
      bus.word_end  <= last;
    end
`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow is carry-in XOR carry-out of the MSB.
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.ovf <= 1'b0;
    else bus.ovf <= last & (c ^ maj);
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder with WIDTH=0 and WIDTH=4.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  serial_adder_if ia();
  serial_adder_if ib();
  serial_adder #(.WIDTH(0)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  serial_adder #(.WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic co;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [3:0] co;
    logic       ov;
  } word_t;

  vec_t  va[14];
  word_t wb[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, " a.sum"}, ia.sum, 1'b0);
    chk({tag, " a.carry_out"}, ia.carry_out, 1'b0);
    chk({tag, " a.word_end"}, ia.word_end, 1'b0);
    chk({tag, " b.sum"}, ib.sum, 1'b0);
    chk({tag, " b.carry_out"}, ib.carry_out, 1'b0);
    chk({tag, " b.word_end"}, ib.word_end, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " b.ovf"}, ib.ovf, 1'b0);
`endif
  endtask

  initial begin
    // 203 + 226 over 9 bits, then 1+1 for 4 cycles and 0+0
    va[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    va[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    va[2]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    va[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    va[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    va[5]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    va[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    va[7]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    va[8]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    va[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    va[10] = '{1'b1, 1'b1, 1'b1, 1'b1};
    va[11] = '{1'b1, 1'b1, 1'b1, 1'b1};
    va[12] = '{1'b1, 1'b1, 1'b1, 1'b1};
    va[13] = '{1'b0, 1'b0, 1'b1, 1'b0};
    // 4-bit framed words: bit i of s/co is the value after the edge for bit i
    wb[0] = '{4'h0, 4'h0, 4'b0000, 4'b0000, 1'b0};
    wb[1] = '{4'hF, 4'h1, 4'b0000, 4'b1111, 1'b0};
    wb[2] = '{4'h0, 4'h0, 4'b0000, 4'b0000, 1'b0};
    wb[3] = '{4'h7, 4'h1, 4'b1000, 4'b0111, 1'b1};
    wb[4] = '{4'hF, 4'h1, 4'b0000, 4'b1111, 1'b0};
    wb[5] = '{4'h5, 4'h6, 4'b1011, 4'b0100, 1'b1};
    ia.in1 = 1'b0; ia.in2 = 1'b0;
    ib.in1 = 1'b0; ib.in2 = 1'b0;

    repeat (10) @(negedge clk);
    chk_zero_all("in reset");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_zero_all("idle after reset");
    end

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ia.in1 = va[i].a; ia.in2 = va[i].b;
      @(posedge clk); #1;
      chk($sformatf("free sum[%0d]", i), ia.sum, va[i].s);
      chk($sformatf("free carry_out[%0d]", i), ia.carry_out, va[i].co);
      chk($sformatf("free word_end[%0d]", i), ia.word_end, 1'b0);
    end

    @(negedge clk);
    ia.in1 = 1'b1; ia.in2 = 1'b1;
    ib.in1 = 1'b1; ib.in2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset a.carry_out", ia.carry_out, 1'b1);
    chk("pre-reset a.sum", ia.sum, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk_zero_all("async reset");
    @(negedge clk);
    ia.in1 = 1'b0; ia.in2 = 1'b0;
    ib.in1 = 1'b0; ib.in2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (w != 0 || k != 0) @(negedge clk);
        ib.in1 = wb[w].a[k]; ib.in2 = wb[w].b[k];
        @(posedge clk); #1;
        chk($sformatf("frame sum w%0d b%0d", w, k), ib.sum, wb[w].s[k]);
        chk($sformatf("frame carry_out w%0d b%0d", w, k), ib.carry_out, wb[w].co[k]);
        chk($sformatf("frame word_end w%0d b%0d", w, k), ib.word_end, k == 3);
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("frame ovf w%0d b%0d", w, k), ib.ovf, (k == 3) && wb[w].ov);
`endif
        chk($sformatf("idle a.sum w%0d b%0d", w, k), ia.sum, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
